// File: rtl/enc_tag_checker.sv
// ---------------------------------------------------------------------------
// enc_tag_checker
//
// Receive-side tag checker for the 8-bit encrypt datapath. Each incoming byte
// is {tag[3:0], payload[3:0]}. The block recomputes the tag from the payload
// nibble and the key, then hands back the nibble with a pass/fail verdict over
// a valid/ready handshake. It keeps saturating pass/fail statistics. After
// MAX_FAIL consecutive failures it locks out further input until it sees an
// unlock pulse.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset       synchronous, active-high
//   in_valid    enc_in/key_in valid
//   in_ready    block can accept a byte (IDLE only)
//   enc_in      {tag[3:0], payload[3:0]}
//   key_in      key used at encryption
//   out_valid   result valid
//   out_ready   downstream accepts result
//   data_out    recovered payload nibble
//   tag_ok      1 = recomputed tag matched enc_in[7:4]
//   pass_count  saturating count of passes
//   fail_count  saturating count of failures
//   locked      lockout active
//   unlock      one-cycle pulse that clears lockout (honoured in LOCK only)
// ---------------------------------------------------------------------------
module enc_tag_checker #(
  parameter int MAX_FAIL = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       enc_in,
  input  logic [7:0]       key_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic             tag_ok,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             locked,
  input  logic             unlock
);

  typedef enum logic [1:0] {IDLE, CALC, OUT, LOCK} state_t;

  localparam logic [3:0]       MAX_FAIL_L = 4'(MAX_FAIL);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state;
  logic [7:0] enc_p0;
  logic [7:0] key_p0;
  logic [3:0] fail_streak;
  logic       tag_match;

  // Tag recompute: scatter the payload bits into a byte, whiten it with the
  // key, then fold the two nibbles together with the key LSB as carry-in.
  // The 5-bit sum keeps the carry visible; only the low nibble is the tag.
  function automatic logic [3:0] tag_calc(input logic [3:0] p, input logic [7:0] k);
    logic [7:0] e;
    logic [7:0] x;
    logic [4:0] s;
    e = {p[3], p[0], p[1], p[2], p[1], p[3], p[2], p[0]};
    x = e ^ k;
    s = {1'b0, x[7:4]} + {1'b0, x[3:0]} + {4'b0000, k[0]};
    return s[3:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [3:0] streak_inc(input logic [3:0] s);
    return (s == MAX_FAIL_L) ? s : s + 4'd1;
  endfunction

  assign tag_match = (tag_calc(enc_p0[3:0], key_p0) == enc_p0[7:4]);

  // Stage p0: capture the accepted byte and key
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      enc_p0 <= enc_in;
      key_p0 <= key_in;
    end
  end

  // Stage p1: verdict, statistics and handshake control
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      locked      <= 1'b0;
      data_out    <= 4'd0;
      tag_ok      <= 1'b0;
      pass_count  <= '0;
      fail_count  <= '0;
      fail_streak <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          data_out  <= enc_p0[3:0];
          tag_ok    <= tag_match;
          out_valid <= 1'b1;
          state     <= OUT;
          if (tag_match) begin
            pass_count  <= sat_inc(pass_count);
            fail_streak <= 4'd0;
          end else begin
            fail_count  <= sat_inc(fail_count);
            fail_streak <= streak_inc(fail_streak);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Lockout only after the failing result has been delivered.
            if (fail_streak == MAX_FAIL_L) begin
              locked <= 1'b1;
              state  <= LOCK;
            end else begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        LOCK: begin
          if (unlock) begin
            fail_streak <= 4'd0;
            locked      <= 1'b0;
            in_ready    <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_tag_checker.sv
// ---------------------------------------------------------------------------
// tb_enc_tag_checker
//
// Directed bench for enc_tag_checker. A transaction-level model tracks the
// expected results (queue), statistics, fail streak and lockout. A per-cycle
// compare process checks the DUT against it, and literal expectations taken
// from hand-worked vectors pin the model.
// ---------------------------------------------------------------------------
module tb_enc_tag_checker;

  localparam int MAX_FAIL = 3;
  localparam int CNT_W    = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             out_ready;
  logic             unlock;
  logic [7:0]       enc_in;
  logic [7:0]       key_in;
  logic             in_ready;
  logic             out_valid;
  logic             tag_ok;
  logic             locked;
  logic [3:0]       data_out;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;

  enc_tag_checker #(.MAX_FAIL(MAX_FAIL), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .enc_in(enc_in), .key_in(key_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .tag_ok(tag_ok),
    .pass_count(pass_count), .fail_count(fail_count), .locked(locked),
    .unlock(unlock)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Tag rule written out bit by bit on integers.
  function automatic int model_tag(input int p, input int k);
    int e;
    int x;
    e = (((p >> 3) & 1) << 7) | ((p & 1) << 6) | (((p >> 1) & 1) << 5) |
        (((p >> 2) & 1) << 4) | (((p >> 1) & 1) << 3) | (((p >> 3) & 1) << 2) |
        (((p >> 2) & 1) << 1) | (p & 1);
    x = e ^ k;
    return ((x >> 4) + (x & 15) + (k & 1)) % 16;
  endfunction

  // Model state
  int exp_data[$];
  int exp_ok[$];
  int m_pass, m_fail, m_streak, age, m_okv;
  bit m_locked;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      exp_data.delete();
      exp_ok.delete();
      m_pass   = 0;
      m_fail   = 0;
      m_streak = 0;
      m_locked = 1'b0;
      age      = 0;
    end else begin
      if (unlock && m_locked) begin
        m_locked = 1'b0;
        m_streak = 0;
      end else if (in_valid && exp_data.size() == 0 && !m_locked) begin
        m_okv = (model_tag(int'(enc_in[3:0]), int'(key_in)) == int'(enc_in[7:4])) ? 1 : 0;
        exp_data.push_back(int'(enc_in[3:0]));
        exp_ok.push_back(m_okv);
        if (m_okv == 1) begin
          if (m_pass < CNT_MAX) m_pass++;
          m_streak = 0;
        end else begin
          if (m_fail < CNT_MAX) m_fail++;
          if (m_streak < MAX_FAIL) m_streak++;
        end
        age = 0;
      end else if (exp_data.size() > 0) begin
        if (age >= 1 && out_ready) begin
          void'(exp_data.pop_front());
          void'(exp_ok.pop_front());
          if (m_streak == MAX_FAIL) m_locked = 1'b1;
        end else begin
          age++;
        end
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, (exp_data.size() == 0 && !m_locked));
      check("out_valid", out_valid, (exp_data.size() > 0 && age >= 1));
      check("locked", locked, m_locked);
      if (!(exp_data.size() > 0 && age == 0)) begin
        check("pass_count", pass_count, m_pass);
        check("fail_count", fail_count, m_fail);
      end
      if (out_valid && exp_data.size() > 0) begin
        check("data_out", data_out, exp_data[0]);
        check("tag_ok", tag_ok, exp_ok[0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] e, input logic [7:0] k);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step(1);
      n++;
    end
    if (n >= 50) check("send_timeout", 0, 1);
    enc_in   = e;
    key_in   = k;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step(1);
      n++;
    end
    if (n >= 50) check("out_timeout", 0, 1);
  endtask

  // Full transfer with out_ready high: accept, result, handshake.
  task automatic xfer(input logic [7:0] e, input logic [7:0] k);
    send(e, k);
    wait_out();
    step(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    unlock    = 1'b0;
    enc_in    = 8'h00;
    key_in    = 8'h00;
    step(1);
    chk_en = 1'b1;
    step(1);
    reset = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_data_out", data_out, 0);
    check("rst_tag_ok", tag_ok, 0);
    check("rst_pass", pass_count, 0);
    check("rst_fail", fail_count, 0);

    // Basic pass and one-cycle latency
    send(8'h46, 8'h93);
    check("lat_vld_early", out_valid, 0);
    step(1);
    check("lat_vld", out_valid, 1);
    check("v1_data", data_out, 4'b0110);
    check("v1_tag", tag_ok, 1);
    check("v1_pass", pass_count, 1);
    step(1);
    check("v1_back_idle", in_ready, 1);

    xfer(8'hF9, 8'hAC);
    check("v2_data", data_out, 4'b1001);
    check("v2_tag", tag_ok, 1);
    xfer(8'hE9, 8'hAC);
    check("v3_tag", tag_ok, 0);
    check("v3_fail", fail_count, 1);

    // Backpressure
    out_ready = 1'b0;
    send(8'h46, 8'h93);
    step(1);
    check("bp_vld", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("bp_hold_vld", out_valid, 1);
      check("bp_hold_data", data_out, 4'b0110);
      check("bp_hold_tag", tag_ok, 1);
      check("bp_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    step(1);
    check("bp_done_vld", out_valid, 0);
    check("bp_done_rdy", in_ready, 1);

    // Streak reset: fail, fail, pass, fail
    do_reset();
    xfer(8'hE9, 8'hAC);
    xfer(8'hE9, 8'hAC);
    xfer(8'h46, 8'h93);
    xfer(8'hE9, 8'hAC);
    check("streak_locked", locked, 0);
    check("streak_fail", fail_count, 3);
    check("streak_pass", pass_count, 1);
    check("streak_rdy", in_ready, 1);

    // Lockout
    do_reset();
    xfer(8'hE9, 8'hAC);
    xfer(8'hE9, 8'hAC);
    check("pre_lock", locked, 0);
    xfer(8'hE9, 8'hAC);
    check("lock_set", locked, 1);
    enc_in   = 8'h46;
    key_in   = 8'h93;
    in_valid = 1'b1;
    step(3);
    check("lock_rdy", in_ready, 0);
    check("lock_no_out", out_valid, 0);
    in_valid = 1'b0;
    unlock   = 1'b1;
    step(1);
    unlock = 1'b0;
    check("unlock_locked", locked, 0);
    check("unlock_rdy", in_ready, 1);
    check("unlock_fail_kept", fail_count, 3);

    // Unlock while idle does nothing
    unlock = 1'b1;
    step(1);
    unlock = 1'b0;
    check("idle_unlock_rdy", in_ready, 1);

    // Reset and unlock together: reset wins
    xfer(8'hE9, 8'hAC);
    xfer(8'hE9, 8'hAC);
    xfer(8'hE9, 8'hAC);
    check("relock", locked, 1);
    reset  = 1'b1;
    unlock = 1'b1;
    step(1);
    reset  = 1'b0;
    unlock = 1'b0;
    check("rstunl_locked", locked, 0);
    check("rstunl_fail", fail_count, 0);
    check("rstunl_rdy", in_ready, 1);

    // Reset while a result is pending
    out_ready = 1'b0;
    send(8'h46, 8'h93);
    step(1);
    check("pend_vld", out_valid, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("pend_rst_vld", out_valid, 0);
    check("pend_rst_rdy", in_ready, 1);
    check("pend_rst_pass", pass_count, 0);
    check("pend_rst_data", data_out, 0);
    check("pend_rst_tag", tag_ok, 0);
    out_ready = 1'b1;
    step(2);

    // Counter saturation
    for (int i = 0; i < 4; i++) begin
      xfer(8'hE9, 8'hAC);
      xfer(8'hE9, 8'hAC);
      xfer(8'hF9, 8'hAC);
    end
    check("sat_fail", fail_count, CNT_MAX);
    check("sat_pass_mid", pass_count, 4);
    for (int i = 0; i < 4; i++) xfer(8'h46, 8'h93);
    check("sat_pass", pass_count, CNT_MAX);
    check("sat_locked", locked, 0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
